esp_dma64_write_coalescer: RTL and testbench

//  Sits between X-HEEP-side 64-bit store traffic and the ESP DMA write ctrl/chnl ports of the accelerator top.

---
 rtl/esp_dma64_write_coalescer.sv | 175 +++++++++++++++++
 tb/tb_esp_dma64_write_coalescer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esp_dma64_write_coalescer.sv
// Purpose: merges contiguous 64-bit store beats into a buffered burst and issues one ESP DMA write per burst.
// Latency: a 1-beat burst closed by flush shows ctrl valid 2 cycles after the accept; data starts the cycle after the ctrl handshake.
// Backpressure: in_ready_o is low in CTRL/DATA; ctrl/chnl valids hold with stable payload until their ready handshake.
module esp_dma64_write_coalescer #(
    parameter int unsigned MAX_BEATS      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_index_i,
    input  logic [63:0] in_data_i,
    input  logic        flush_i,
    output logic        dma_write_ctrl_valid_o,
    input  logic        dma_write_ctrl_ready_i,
    output logic [31:0] dma_write_ctrl_data_index_o,
    output logic [31:0] dma_write_ctrl_data_length_o,
    output logic [2:0]  dma_write_ctrl_data_size_o,
    output logic [5:0]  dma_write_ctrl_data_user_o,
    output logic        dma_write_chnl_valid_o,
    input  logic        dma_write_chnl_ready_i,
    output logic [63:0] dma_write_chnl_data_o,
    output logic        busy_o,
    output logic [15:0] bursts_issued_o
);

    localparam int unsigned PTR_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_CTRL = 2'd2,
        S_DATA = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]        bursts_q, bursts_d;
    logic [63:0]        buf_q [MAX_BEATS];

    logic               wr_en;
    logic [PTR_W-1:0]   wr_ptr;
    logic               in_rdy;
    logic               ctrl_vld;
    logic               chnl_vld;
    logic [32:0]        next_idx;
    logic               contig;
    logic               count_full;
    logic               timer_expired;

    // Next expected index; a carry out of bit 31 means the burst would wrap the index space.
    always_comb begin
        next_idx      = {1'b0, base_q} + 33'(count_q);
        contig        = (in_index_i == next_idx[31:0]) && !next_idx[32];
        count_full    = (count_q == CNT_W'(MAX_BEATS));
        // Checking the incremented timer makes ctrl valid appear exactly TIMEOUT_CYCLES after the last accept.
        timer_expired = ((32'(timer_q) + 32'd1) >= (TIMEOUT_CYCLES - 32'd1));
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        timer_d  = timer_q;
        rd_ptr_d = rd_ptr_q;
        bursts_d = bursts_q;
        wr_en    = 1'b0;
        wr_ptr   = '0;
        in_rdy   = 1'b0;
        ctrl_vld = 1'b0;
        chnl_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_rdy = 1'b1;
                if (in_valid_i) begin
                    base_d  = in_index_i;
                    count_d = CNT_W'(1);
                    timer_d = '0;
                    wr_en   = 1'b1;
                    wr_ptr  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                in_rdy = contig && !flush_i && !count_full;
                if (in_valid_i && in_rdy) begin
                    wr_en   = 1'b1;
                    wr_ptr  = count_q[PTR_W-1:0];
                    count_d = count_q + CNT_W'(1);
                    timer_d = '0;
                    if (count_q == CNT_W'(MAX_BEATS - 1)) begin
                        state_d = S_CTRL;
                    end
                end else if (flush_i || (in_valid_i && !contig)) begin
                    // A rejected non-contiguous beat stays at the source and opens the next burst.
                    state_d = S_CTRL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (timer_expired) begin
                        state_d = S_CTRL;
                    end
                end
            end
            S_CTRL: begin
                ctrl_vld = 1'b1;
                if (dma_write_ctrl_ready_i) begin
                    rd_ptr_d = '0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                chnl_vld = 1'b1;
                if (dma_write_chnl_ready_i) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (({1'b0, rd_ptr_q} + CNT_W'(1)) == count_q) begin
                        count_d  = '0;
                        bursts_d = bursts_q + 16'd1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state; reset abandons any buffered burst without finishing its DMA traffic.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            rd_ptr_q <= '0;
            bursts_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            rd_ptr_q <= rd_ptr_d;
            bursts_q <= bursts_d;
        end
    end

    // Beat buffer; contents are only meaningful below count_q, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (wr_en && rst_ni) begin
            buf_q[wr_ptr] <= in_data_i;
        end
    end

    // Outputs are forced to zero while reset is asserted; payloads are zero outside their valid phase.
    always_comb begin
        in_ready_o                   = rst_ni && in_rdy;
        dma_write_ctrl_valid_o       = rst_ni && ctrl_vld;
        dma_write_ctrl_data_index_o  = (rst_ni && ctrl_vld) ? base_q : 32'd0;
        dma_write_ctrl_data_length_o = (rst_ni && ctrl_vld) ? 32'(count_q) : 32'd0;
        dma_write_ctrl_data_size_o   = 3'b011;
        dma_write_ctrl_data_user_o   = 6'd0;
        dma_write_chnl_valid_o       = rst_ni && chnl_vld;
        dma_write_chnl_data_o        = (rst_ni && chnl_vld) ? buf_q[rd_ptr_q] : 64'd0;
        busy_o                       = rst_ni && (state_q != S_IDLE);
        bursts_issued_o              = rst_ni ? bursts_q : 16'd0;
    end

endmodule

// File: tb/tb_esp_dma64_write_coalescer.sv
// Purpose: directed, table-driven bench for esp_dma64_write_coalescer with randomly stalled DMA readies.
// Latency: checks flush and idle-timeout closing latency plus burst boundaries.
// Backpressure: a negedge monitor owns the DMA readies and checks payload stability under stalls.
module tb_esp_dma64_write_coalescer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_index;
    logic [63:0] in_data;
    logic        flush;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic [31:0] ctrl_index;
    logic [31:0] ctrl_len;
    logic [2:0]  ctrl_size;
    logic [5:0]  ctrl_user;
    logic        chnl_valid;
    logic        chnl_ready;
    logic [63:0] chnl_data;
    logic        busy;
    logic [15:0] bursts_issued;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_total = 0;
    int acc_cyc = 0;

    bit rand_en  = 1'b1;
    bit ctrl_req = 1'b0;
    bit chnl_req = 1'b0;

    logic [63:0] ctrl_q [$];
    logic [63:0] data_q [$];

    typedef struct {
        logic [31:0] start;
        int          n;
        bit          has_extra;
        logic [31:0] extra;
        bit          use_flush;
        int          nb;
        logic [31:0] b0;
        int          l0;
        logic [31:0] b1;
        int          l1;
    } vec_t;

    vec_t vecs [5];

    esp_dma64_write_coalescer #(
        .MAX_BEATS      (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_i                        (clk),
        .rst_ni                       (rst_n),
        .in_valid_i                   (in_valid),
        .in_ready_o                   (in_ready),
        .in_index_i                   (in_index),
        .in_data_i                    (in_data),
        .flush_i                      (flush),
        .dma_write_ctrl_valid_o       (ctrl_valid),
        .dma_write_ctrl_ready_i       (ctrl_ready),
        .dma_write_ctrl_data_index_o  (ctrl_index),
        .dma_write_ctrl_data_length_o (ctrl_len),
        .dma_write_ctrl_data_size_o   (ctrl_size),
        .dma_write_ctrl_data_user_o   (ctrl_user),
        .dma_write_chnl_valid_o       (chnl_valid),
        .dma_write_chnl_ready_i       (chnl_ready),
        .dma_write_chnl_data_o        (chnl_data),
        .busy_o                       (busy),
        .bursts_issued_o              (bursts_issued)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] beat_dat(input logic [31:0] idx);
        return {idx ^ 32'hA5A5_5A5A, idx};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: drives readies for the coming edge, then records handshakes and checks invariants.
    initial begin
        bit          pc_hold = 1'b0;
        bit          pd_hold = 1'b0;
        logic [63:0] pc_val  = '0;
        logic [63:0] pd_val  = '0;
        forever begin
            @(negedge clk);
            if (rand_en) begin
                ctrl_ready = ($urandom_range(0, 3) != 0);
                chnl_ready = ($urandom_range(0, 3) != 0);
            end else begin
                ctrl_ready = ctrl_req;
                chnl_ready = chnl_req;
            end
            if (!rst_n) begin
                pc_hold = 1'b0;
                pd_hold = 1'b0;
            end else begin
                chk("valids_exclusive", 64'(ctrl_valid && chnl_valid), 64'd0);
                if (pc_hold) chk("ctrl_stable", {ctrl_index, ctrl_len}, pc_val);
                if (pc_hold) chk("ctrl_valid_held", 64'(ctrl_valid), 64'd1);
                if (pd_hold) chk("chnl_stable", chnl_data, pd_val);
                if (pd_hold) chk("chnl_valid_held", 64'(chnl_valid), 64'd1);
                if (ctrl_valid || chnl_valid) chk("in_ready_low_when_issuing", 64'(in_ready), 64'd0);
                chk("size_user", {55'd0, ctrl_size, ctrl_user}, {55'd0, 3'b011, 6'd0});
                if (ctrl_valid && ctrl_ready) ctrl_q.push_back({ctrl_index, ctrl_len});
                if (chnl_valid && chnl_ready) data_q.push_back(chnl_data);
                pc_hold = ctrl_valid && !ctrl_ready;
                pc_val  = {ctrl_index, ctrl_len};
                pd_hold = chnl_valid && !chnl_ready;
                pd_val  = chnl_data;
            end
        end
    end

    // Presents one beat and holds it until accepted; entered and left at negedge+1.
    task automatic send_beat(input logic [31:0] idx);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_index = idx;
        in_data  = beat_dat(idx);
        for (int g = 0; g < 400; g++) begin
            #1;
            acc = in_ready;
            if (acc) acc_cyc = cyc;
            @(negedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout index=0x%0h never accepted", idx);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_bursts(input string name, input int target);
        for (int g = 0; g < 3000; g++) begin
            if (int'(bursts_issued) == target) break;
            @(negedge clk);
        end
        #1;
        chk(name, 64'(bursts_issued), 64'(target));
    endtask

    task automatic check_bursts(input string tag, input int nb, input logic [31:0] b0,
                                input int l0, input logic [31:0] b1, input int l1);
        int          p = 0;
        logic [31:0] base;
        int          len;
        chk($sformatf("%s_nbursts", tag), 64'(ctrl_q.size()), 64'(nb));
        chk($sformatf("%s_nbeats", tag), 64'(data_q.size()), 64'(l0 + ((nb > 1) ? l1 : 0)));
        for (int i = 0; i < nb; i++) begin
            base = (i == 0) ? b0 : b1;
            len  = (i == 0) ? l0 : l1;
            if (i < ctrl_q.size()) begin
                chk($sformatf("%s_b%0d_index", tag, i), 64'(ctrl_q[i][63:32]), 64'(base));
                chk($sformatf("%s_b%0d_length", tag, i), 64'(ctrl_q[i][31:0]), 64'(len));
            end
            for (int k = 0; k < len; k++) begin
                if (p < data_q.size())
                    chk($sformatf("%s_b%0d_data%0d", tag, i, k), data_q[p], beat_dat(base + 32'(k)));
                p++;
            end
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 4,  1'b0, 32'h0,         1'b1, 1, 32'h0000_0100, 4,  32'h0,  0};
        vecs[1] = '{32'h0000_0000, 20, 1'b0, 32'h0,         1'b0, 2, 32'h0000_0000, 16, 32'h10, 4};
        vecs[2] = '{32'h0000_0010, 2,  1'b1, 32'h0000_0040, 1'b1, 2, 32'h0000_0010, 2,  32'h40, 1};
        vecs[3] = '{32'hFFFF_FFFF, 1,  1'b1, 32'h0000_0000, 1'b0, 2, 32'hFFFF_FFFF, 1,  32'h0,  1};
        vecs[4] = '{32'h0000_0200, 16, 1'b0, 32'h0,         1'b1, 1, 32'h0000_0200, 16, 32'h0,  0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_index   = '0;
        in_data    = '0;
        flush      = 1'b0;
        ctrl_ready = 1'b0;
        chnl_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valids", {62'd0, ctrl_valid, chnl_valid}, 64'd0);
        chk("reset_bursts", 64'(bursts_issued), 64'd0);
        chk("reset_size", 64'(ctrl_size), 64'd3);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        // Table-driven burst scenarios.
        for (int v = 0; v < 5; v++) begin
            ctrl_q.delete();
            data_q.delete();
            for (int k = 0; k < vecs[v].n; k++) send_beat(vecs[v].start + 32'(k));
            if (vecs[v].has_extra) send_beat(vecs[v].extra);
            exp_total += vecs[v].nb;
            if (vecs[v].use_flush) flush = 1'b1;
            wait_bursts($sformatf("v%0d_bursts_issued", v), exp_total);
            @(negedge clk);
            #1;
            flush = 1'b0;
            repeat (8) @(negedge clk);
            #1;
            chk($sformatf("v%0d_busy_after", v), 64'(busy), 64'd0);
            check_bursts($sformatf("v%0d", v), vecs[v].nb, vecs[v].b0, vecs[v].l0,
                         vecs[v].b1, vecs[v].l1);
        end

        // Flush already high in IDLE: no effect there, then 1-beat burst closes 2 cycles after accept.
        ctrl_q.delete();
        data_q.delete();
        flush = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("flush_idle_busy", 64'(busy), 64'd0);
        send_beat(32'h0000_0700);
        for (int g = 0; g < 200 && !ctrl_valid; g++) @(negedge clk);
        chk("lat_flush_ctrl", 64'(cyc - acc_cyc), 64'd2);
        exp_total += 1;
        wait_bursts("lat_flush_bursts", exp_total);
        flush = 1'b0;
        check_bursts("lat_flush", 1, 32'h0000_0700, 1, 32'h0, 0);

        // Single beat left alone: idle timeout closes it exactly 64 cycles after accept.
        @(negedge clk);
        #1;
        ctrl_q.delete();
        data_q.delete();
        send_beat(32'h0000_0005);
        for (int g = 0; g < 300 && !ctrl_valid; g++) @(negedge clk);
        chk("lat_timeout_ctrl", 64'(cyc - acc_cyc), 64'd64);
        exp_total += 1;
        wait_bursts("lat_timeout_bursts", exp_total);
        check_bursts("lat_timeout", 1, 32'h0000_0005, 1, 32'h0, 0);

        // Reset in DATA after 2 of 4 beats went out.
        @(negedge clk);
        #1;
        ctrl_q.delete();
        data_q.delete();
        rand_en  = 1'b0;
        ctrl_req = 1'b1;
        chnl_req = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(32'h0000_0300 + 32'(k));
        flush = 1'b1;
        for (int g = 0; g < 200 && !chnl_valid; g++) @(negedge clk);
        #1;
        flush    = 1'b0;
        chnl_req = 1'b1;
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            #1;
            if (data_q.size() >= 2) break;
        end
        chnl_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_still_data", 64'(chnl_valid), 64'd1);
        chk("rst_mid_bursts_before", 64'(bursts_issued), 64'(exp_total));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_outputs_zero",
            {ctrl_valid, chnl_valid, in_ready, busy, ctrl_user, bursts_issued, 38'd0},
            64'd0);
        chk("rst_mid_payload_zero", {ctrl_index, ctrl_len} | chnl_data, 64'd0);
        chk("rst_mid_size", 64'(ctrl_size), 64'd3);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        exp_total = 0;
        rand_en   = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_after_busy", 64'(busy), 64'd0);
        chk("rst_after_bursts", 64'(bursts_issued), 64'd0);
        chk("rst_after_in_ready", 64'(in_ready), 64'd1);
        chk("rst_partial_ctrl", ctrl_q.size() > 0 ? ctrl_q[0] : 64'd0, {32'h0000_0300, 32'd4});
        chk("rst_partial_beats", 64'(data_q.size()), 64'd2);

        // Fresh burst after reset: buffered beats from before the reset are gone.
        ctrl_q.delete();
        data_q.delete();
        send_beat(32'h0000_0400);
        flush = 1'b1;
        exp_total += 1;
        wait_bursts("post_rst_bursts", exp_total);
        flush = 1'b0;
        check_bursts("post_rst", 1, 32'h0000_0400, 1, 32'h0, 0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
